// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches and buffers returned
// instructions with their PC for the IF/ID register. FETCH_PERF_EN adds fetch/redirect counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [63:0] if_id_bundle
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_redirect_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [PTR_W-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
   logic               req_valid_q, req_valid_d;
   logic               if_valid_q, if_valid_d;
   logic [63:0]        bundle_q, bundle_d;

   logic [31:0]        tag_q  [DEPTH];
   logic [63:0]        fifo_q [DEPTH];

   logic               hs, push, pop, rsp_hit;
   logic [CNT_W-1:0]   drop_base, remain;
   logic [SUM_W-1:0]   credit_d;
   logic [63:0]        rsp_entry;

   assign hs   = req_valid_q & imem_req_ready;
   assign pop  = !redirect_valid && !stall && (cnt_q != '0);
   assign push = !redirect_valid && (state_q == S_FETCH) && imem_rsp_valid && (inflight_q != '0);

   // A response is charged against the drop count only if something is actually outstanding
   assign rsp_hit = imem_rsp_valid &&
                    ((state_q == S_DRAIN) ? (drop_q != '0)
                                          : ((state_q == S_FETCH) && (inflight_q != '0)));
   assign drop_base = (state_q == S_DRAIN) ? drop_q : (inflight_q + CNT_W'(hs));
   assign remain    = cnt_q - CNT_W'(pop);
   assign rsp_entry = {tag_q[tag_rd_q], imem_rsp_data};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inflight_d  = inflight_q;
      drop_d      = drop_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      tag_rd_d    = tag_rd_q;
      tag_wr_d    = tag_wr_q;
      bundle_d    = {32'h0, NOP_INSTR};
      if_valid_d  = 1'b0;
      req_valid_d = 1'b0;
      credit_d    = '0;

      if (redirect_valid) begin
         pc_d       = redirect_pc & ~32'h3;
         inflight_d = '0;
         cnt_d      = '0;
         rd_d       = '0;
         wr_d       = '0;
         tag_rd_d   = '0;
         tag_wr_d   = '0;
         drop_d     = drop_base - CNT_W'(rsp_hit);
         state_d    = (drop_d != '0) ? S_DRAIN : S_FETCH;
      end else begin
         if (hs) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = tag_wr_q + PTR_W'(1);
         end
         if (push) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
            wr_d     = wr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_d = rd_q + PTR_W'(1);
         end
         inflight_d = inflight_q + CNT_W'(hs) - CNT_W'(push);
         cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
         case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_DRAIN: begin
               drop_d = drop_q - CNT_W'(rsp_hit);
               if (drop_d == '0) begin
                  state_d = S_FETCH;
               end
            end
            default: ;
         endcase
      end

      // Next head: a push into an emptied buffer bypasses straight to the output register
      if (cnt_d != '0) begin
         if_valid_d = 1'b1;
         bundle_d   = (remain == '0) ? rsp_entry : fifo_q[rd_d];
      end

      credit_d    = SUM_W'(inflight_d) + SUM_W'(cnt_d);
      req_valid_d = (state_d == S_FETCH) && (credit_d < SUM_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         inflight_q  <= '0;
         drop_q      <= '0;
         cnt_q       <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
         tag_rd_q    <= '0;
         tag_wr_q    <= '0;
         req_valid_q <= 1'b0;
         if_valid_q  <= 1'b0;
         bundle_q    <= {32'h0, NOP_INSTR};
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         tag_rd_q    <= tag_rd_d;
         tag_wr_q    <= tag_wr_d;
         req_valid_q <= req_valid_d;
         if_valid_q  <= if_valid_d;
         bundle_q    <= bundle_d;
      end
   end

   // Storage arrays carry no reset; occupancy is tracked by the pointers and counters
   always_ff @(posedge clk) begin
      if (hs) begin
         tag_q[tag_wr_q] <= pc_q;
      end
      if (push) begin
         fifo_q[wr_q] <= rsp_entry;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign if_id_valid    = if_valid_q;
   assign if_id_bundle   = bundle_q;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_redirect_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetch_q    <= '0;
         perf_redirect_q <= '0;
      end else begin
         perf_fetch_q    <= perf_fetch_q + 32'(pop);
         perf_redirect_q <= perf_redirect_q + 32'(redirect_valid);
      end
   end

   assign perf_fetch_cnt    = perf_fetch_q;
   assign perf_redirect_cnt = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order random-latency memory plus a transaction-level model
// of the expected PC stream, outstanding credit and drop behaviour.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [63:0] if_id_bundle;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_redirect_cnt;
`endif

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (RESET_PC),
      .DEPTH     (DEPTH),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_bundle   (if_id_bundle)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt    (perf_fetch_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );

   // kind: 0 = live request, 1 = dropped by redirect, 2 = orphaned by reset
   typedef struct {
      logic [31:0] addr;
      int          due;
      int          kind;
   } mreq_t;

   mreq_t       mq[$];
   int          cyc;
   int          last_due;
   int          lat_min, lat_max, ready_pct;
   int          vectors, errs;
   logic [31:0] exp_pc, exp_req_pc;
   int          live, ready_cnt;
   bit          in_idle;
   int          pops, redirs;
   int          n;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
   endfunction

   function automatic int count_kind(input int k);
      int s;
      s = 0;
      foreach (mq[i]) if (mq[i].kind == k) s++;
      return s;
   endfunction

   function automatic bit exp_req_valid();
      return (reset === 1'b1) && !in_idle && (count_kind(1) == 0) && (live < int'(DEPTH));
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_mem();
      bit orphan;
      orphan = (count_kind(2) != 0);
      imem_req_ready = !orphan && (int'($urandom_range(99, 0)) < ready_pct);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   task automatic check_outputs();
      bit ev;
      ev = exp_req_valid();
      chk("if_id_valid", 64'(if_id_valid), 64'(ready_cnt > 0));
      chk("if_id_bundle", if_id_bundle,
          (ready_cnt > 0) ? {exp_pc, mem_word(exp_pc)} : {32'h0, NOP});
      chk("req_valid", 64'(imem_req_valid), 64'(ev));
      if (ev) chk("req_addr", 64'(imem_req_addr), 64'(exp_req_pc));
   endtask

   task automatic tick();
      bit          rs, rd, st, dhs, mhs, dlv, pp;
      int          dk, due;
      logic [31:0] rpc, a;
      rs  = (reset === 1'b1);
      rd  = redirect_valid;
      st  = stall;
      rpc = redirect_pc;
      dhs = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      mhs = exp_req_valid() && imem_req_ready;
      dlv = imem_rsp_valid;
      dk  = (mq.size() > 0) ? mq[0].kind : 0;
      pp  = rs && (ready_cnt > 0) && !st && !rd;
      @(posedge clk);
      cyc++;
      if (dlv && mq.size() > 0) void'(mq.pop_front());
      if (dhs) begin
         due = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
         if (mq.size() > 0 && due <= last_due) due = last_due + 1;
         last_due = due;
         mq.push_back('{addr: a, due: due, kind: 0});
      end
      if (!rs) begin
         in_idle = 1'b1;
      end else begin
         if (rd) begin
            redirs++;
            live       = 0;
            ready_cnt  = 0;
            exp_pc     = rpc & ~32'h3;
            exp_req_pc = rpc & ~32'h3;
            foreach (mq[i]) if (mq[i].kind == 0) mq[i].kind = 1;
         end else begin
            if (dlv && dk == 0) ready_cnt++;
            if (pp) begin
               ready_cnt--;
               live--;
               exp_pc += 32'd4;
               pops++;
            end
            if (mhs) begin
               live++;
               exp_req_pc += 32'd4;
            end
         end
         in_idle = 1'b0;
      end
      #1;
      drive_mem();
      check_outputs();
   endtask

   task automatic async_reset();
      reset = 1'b0;
      #1;
      foreach (mq[i]) mq[i].kind = 2;
      live       = 0;
      ready_cnt  = 0;
      exp_pc     = RESET_PC;
      exp_req_pc = RESET_PC;
      in_idle    = 1'b1;
      pops       = 0;
      redirs     = 0;
      drive_mem();
      check_outputs();
   endtask

   initial begin
      vectors = 0; errs = 0; cyc = 0; last_due = 0;
      lat_min = 1; lat_max = 1; ready_pct = 100;
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      reset = 1'b1;
      #1;
      async_reset();
      tick();
      tick();
      reset = 1'b1;

      // Latency 1, always ready: first valid bundle three cycles after release
      n = 0;
      while (!if_id_valid && n < 10) begin tick(); n++; end
      chk("first_valid_cycles", 64'(n), 64'd3);
      chk("first_pc", 64'(if_id_bundle[63:32]), 64'(RESET_PC));

      // Stall holding PC 0x8
      n = 0;
      while (if_id_bundle[63:32] !== 32'h8 && n < 20) begin tick(); n++; end
      chk("reach_pc8", 64'(if_id_bundle[63:32]), 64'h8);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_hold", if_id_bundle, {32'h8, mem_word(32'h8)});
      end
      stall = 1'b0;
      tick();
      chk("after_stall_pc", 64'(if_id_bundle[63:32]), 64'hC);

      // Redirect to 0x100 with two requests in flight
      lat_min = 3; lat_max = 3;
      n = 0;
      while (count_kind(0) != 2 && n < 30) begin tick(); n++; end
      chk("two_inflight", 64'(count_kind(0)), 64'd2);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      n = 0;
      while (!imem_req_valid && n < 20) begin tick(); n++; end
      chk("redir_req_addr", 64'(imem_req_addr), 64'h100);
      n = 0;
      while (!if_id_valid && n < 20) begin tick(); n++; end
      chk("redir_bundle_pc", 64'(if_id_bundle[63:32]), 64'h100);

      // Redirect together with stall, unaligned target
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
      tick();
      stall = 1'b0; redirect_valid = 1'b0;
      chk("bubble_bundle", if_id_bundle, {32'h0, NOP});
      chk("bubble_valid", 64'(if_id_valid), 64'd0);
      n = 0;
      while (!imem_req_valid && n < 20) begin tick(); n++; end
      chk("aligned_req_addr", 64'(imem_req_addr), 64'h200);

      // Reset in the middle of a burst
      n = 0;
      while (count_kind(0) != 2 && n < 30) begin tick(); n++; end
      #2;
      async_reset();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_bundle", if_id_bundle, {32'h0, NOP});
      tick();
      reset = 1'b1;
      n = 0;
      while (!if_id_valid && n < 30) begin tick(); n++; end
      chk("restart_pc", 64'(if_id_bundle[63:32]), 64'(RESET_PC));

      // Randomised traffic, including a redirect near the top of the address space
      lat_min = 1; lat_max = 4; ready_pct = 70;
      for (int i = 0; i < 1500; i++) begin
         stall          = (int'($urandom_range(99, 0)) < 25);
         redirect_valid = (i == 10) || (int'($urandom_range(99, 0)) < 4);
         redirect_pc    = (i == 10) ? 32'hFFFF_FFF8 : $urandom;
         tick();
      end
      stall = 1'b0; redirect_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();

`ifdef FETCH_PERF_EN
      chk("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(unsigned'(pops)));
      chk("perf_redirect_cnt", 64'(perf_redirect_cnt), 64'(unsigned'(redirs)));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
